e1_tx_line_driver: RTL and testbench
====================================

Name: e1_tx_line_driver

Overview:
- Transmit-side counterpart of the E1 RX sampling/clock-recovery path.
- Takes one bipolar symbol per bit period (hi = positive mark, lo = negative mark, neither = space) from the HDB3 encoder.
- Generates the local 2.048 Mb/s bit timing from the system clock and drives RZ pulses to the line-interface pads.
- Sits between the TX framer/HDB3 encoder and the pad drivers. Optional trim inputs slave the bit period to a recovered RX clock.

Parameters:
- DIV, 15, system clocks per bit period (30.72 MHz / 15 = 2.048 MHz); legal 4..63
- PULSE_W, 7, clocks each mark pulse is driven (nominal 50% RZ); legal 1..DIV-2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_hi  in  1  symbol is positive mark
- in_lo  in  1  symbol is negative mark
- in_valid  in  1  symbol present
- in_ready  out  1  one-cycle symbol accept, high only on bit-slot tick
- pad_hi  out  1  positive pulse to line driver
- pad_lo  out  1  negative pulse to line driver
- bit_stb  out  1  one-cycle pulse at start of each transmitted bit
- underrun  out  1  one-cycle pulse when a bit slot had no symbol
- trim_slow  in  1  (E1_TX_TRIM_EN only) lengthen one bit period by 1 clk
- trim_fast  in  1  (E1_TX_TRIM_EN only) shorten one bit period by 1 clk

Behaviour:
- Reset values:
  - Period counter cnt = DIV-1 (width $clog2(DIV)).
  - pad_hi = pad_lo = bit_stb = underrun = 0; pulse counter = 0; trim pendings = 0.
  - Reset mid-pulse kills the pulse on the next edge.
- Timing:
  - tick = (cnt == 0). cnt decrements each clk; on tick it reloads DIV-1.
  - First tick occurs DIV-1 clks after rst deasserts.
- Handshake:
  - in_ready = tick, combinational from cnt only; never depends on in_valid.
  - Transfer occurs when in_valid & in_ready. No transfer ever occurs outside a tick. The upstream holds the symbol until accepted.
- Latency: on the clk after a tick:
  - bit_stb = 1 for exactly one cycle.
  - pad_hi <= in_hi & ~in_lo & in_valid, and pad_lo <= in_lo & ~in_hi & in_valid.
  - Pulse counter loads PULSE_W-1 if a mark was launched.
- Pulse shaping:
  - The pad stays high while the pulse counter is nonzero, plus the load cycle: exactly PULSE_W clks high.
  - The pad drops to 0 afterwards. pad_hi and pad_lo are never both 1.
- Illegal symbol (in_hi & in_lo with in_valid): accepted and transmitted as a space; no flag.
- Underrun: tick with in_valid = 0:
  - Space is transmitted; bit_stb still pulses.
  - underrun = 1 for one cycle, aligned with bit_stb.
- Back-to-back marks: the pulse ends at least 2 clks before the next tick (PULSE_W <= DIV-2), so the pads always return to zero between bits.
- Outputs pad_hi, pad_lo, bit_stb and underrun are all registered.

Optional Feature:
- Macro E1_TX_TRIM_EN.
- When defined:
  - trim_slow/trim_fast pulses set sticky pending flags.
  - At the next tick the reload value is DIV (if slow pending), DIV-2 (if fast pending), or DIV-1 (both or neither); the applied flags then clear.
  - A trim pulse arriving on the tick cycle itself is deferred to the following tick.
  - At most one adjustment per bit. Repeated pulses before a tick collapse into one.
- When undefined: trim ports are absent and the reload is always DIV-1.

Decomposition:
- Shared package e1_pkg: E1_CLK_DIV_DEFAULT = 15, E1_TX_PULSE_W_DEFAULT = 7, and a 2-bit symbol encoding (SPACE, MARK_POS, MARK_NEG, ILLEGAL) shared with the HDB3 encoder/decoder.
- The block is a single module. The period/trim counter is the only candidate sub-module (e1_tx_bit_timer); keeping it inline is acceptable.

Test Plan:
- Reset, in_valid = 0 for 100 clks -> first in_ready at clk 14 after reset release. Then bit_stb and underrun pulse every 15 clks, and the pads stay 0.
- Continuous in_hi stream -> pad_hi high 7 clks out of every 15, starting the clk after each in_ready. pad_lo is never 1. No underrun.
- Alternating +/-/space pattern -> pads replay it exactly, one bit per 15 clks, with no symbol lost or duplicated.
- in_hi = in_lo = 1 with in_valid -> both pads stay 0 for that bit, symbol consumed, no underrun.
- E1_TX_TRIM_EN: trim_slow once -> next period 16 clks; trim_fast once -> 14 clks; both in the same bit -> 15 clks; trim on the tick cycle -> applied one bit later.
- Assert rst during a pad_hi pulse -> pad_hi 0 the next clk, cnt back to 14, no spurious bit_stb.

Source files
------------

// File: rtl/e1_pkg.sv
`default_nettype none
// ============================================================================
// Package  : e1_pkg
// Purpose  : Constants and the 2-bit bipolar symbol encoding shared by the
//            E1 TX line driver and the HDB3 encoder/decoder.
// Contents : E1_CLK_DIV_DEFAULT    - system clocks per E1 bit (30.72 MHz / 15)
//            E1_TX_PULSE_W_DEFAULT - clocks a mark pulse is driven (~50% RZ)
//            sym_t                 - SPACE / MARK_POS / MARK_NEG / ILLEGAL
//            e1_sym_encode()       - {lo,hi} pair to sym_t
// Revision : 1.0 - initial release
// ============================================================================
package e1_pkg;

  localparam int E1_CLK_DIV_DEFAULT    = 15;
  localparam int E1_TX_PULSE_W_DEFAULT = 7;

  // Bit 0 carries the positive rail, bit 1 the negative rail, so the
  // encoding is simply {lo, hi}; both rails set is a coding violation.
  typedef enum logic [1:0] {
    SPACE    = 2'b00,
    MARK_POS = 2'b01,
    MARK_NEG = 2'b10,
    ILLEGAL  = 2'b11
  } sym_t;

  function automatic sym_t e1_sym_encode(input logic hi, input logic lo);
    return sym_t'({lo, hi});
  endfunction

endpackage : e1_pkg
`default_nettype wire

// File: rtl/e1_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : e1_tx_bit_timer
// Purpose  : Down-counting bit-period timer. tick is high for the single
//            cycle in which the counter is zero; the counter then reloads.
// Macro    : E1_TX_TRIM_EN - adds trim_slow/trim_fast, which lengthen or
//            shorten one following bit period by one clock.
// Ports    : clk, rst          - system clock, sync active-high reset
//            trim_slow/fast    - (E1_TX_TRIM_EN) one-clock trim requests
//            tick              - bit-slot tick, combinational from cnt
// Revision : 1.0 - initial release
// ============================================================================
module e1_tx_bit_timer #(
  parameter int DIV = 15
) (
  input  logic clk,
  input  logic rst,
`ifdef E1_TX_TRIM_EN
  input  logic trim_slow,
  input  logic trim_fast,
`endif
  output logic tick
);

`ifdef E1_TX_TRIM_EN
  // A slow trim reloads DIV itself, so one extra bit of headroom is needed.
  localparam int CW = $clog2(DIV + 1);
`else
  localparam int CW = $clog2(DIV);
`endif

  logic [CW-1:0] cnt;
  logic [CW-1:0] reload;

  assign tick = (cnt == '0);

`ifdef E1_TX_TRIM_EN
  logic slow_pend;
  logic fast_pend;

  always_comb begin
    reload = CW'(DIV - 1);
    if (slow_pend && !fast_pend) begin
      reload = CW'(DIV);
    end else if (fast_pend && !slow_pend) begin
      reload = CW'(DIV - 2);
    end
  end

  // On a tick the pending flags are consumed; a trim pulse landing on that
  // same cycle becomes the new pending request for the following tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      slow_pend <= 1'b0;
      fast_pend <= 1'b0;
    end else if (tick) begin
      slow_pend <= trim_slow;
      fast_pend <= trim_fast;
    end else begin
      slow_pend <= slow_pend | trim_slow;
      fast_pend <= fast_pend | trim_fast;
    end
  end
`else
  assign reload = CW'(DIV - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CW'(DIV - 1);
    end else if (tick) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule : e1_tx_bit_timer
`default_nettype wire

// File: rtl/e1_tx_line_driver.sv
`default_nettype none
// ============================================================================
// Module   : e1_tx_line_driver
// Purpose  : E1 transmit line driver. Accepts one bipolar symbol per bit
//            slot from the HDB3 encoder and drives RZ mark pulses of
//            PULSE_W clocks onto the positive/negative pad rails.
// Macro    : E1_TX_TRIM_EN - exposes trim_slow/trim_fast to slave the bit
//            period to a recovered RX clock.
// Ports    : clk, rst            - system clock, sync active-high reset
//            in_hi/in_lo/in_valid - symbol from encoder (hi=+, lo=-)
//            in_ready            - accept strobe, high only on bit tick
//            pad_hi/pad_lo       - registered RZ pulses to pad drivers
//            bit_stb             - one-cycle strobe at start of each bit
//            underrun            - one-cycle strobe, bit slot had no symbol
//            trim_slow/trim_fast - (E1_TX_TRIM_EN) period trim requests
// Revision : 1.0 - initial release
// ============================================================================
module e1_tx_line_driver
  import e1_pkg::*;
#(
  parameter int DIV     = E1_CLK_DIV_DEFAULT,
  parameter int PULSE_W = E1_TX_PULSE_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic in_hi,
  input  logic in_lo,
  input  logic in_valid,
  output logic in_ready,
  output logic pad_hi,
  output logic pad_lo,
  output logic bit_stb,
  output logic underrun
`ifdef E1_TX_TRIM_EN
  ,
  input  logic trim_slow,
  input  logic trim_fast
`endif
);

  localparam int PW = $clog2(PULSE_W + 1);

  logic          tick;
  sym_t          sym;
  logic          launch_pos;
  logic          launch_neg;
  logic [PW-1:0] pulse_cnt;

  e1_tx_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
`ifdef E1_TX_TRIM_EN
    .trim_slow (trim_slow),
    .trim_fast (trim_fast),
`endif
    .tick      (tick)
  );

  // Ready is purely the slot tick; it must never look at in_valid.
  assign in_ready = tick;

  // ILLEGAL (both rails) falls through both compares and goes out as space.
  assign sym        = e1_sym_encode(in_hi, in_lo);
  assign launch_pos = in_valid && (sym == MARK_POS);
  assign launch_neg = in_valid && (sym == MARK_NEG);

  // The load cycle plus PULSE_W-1 counted cycles gives PULSE_W clocks high.
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_hi    <= 1'b0;
      pad_lo    <= 1'b0;
      bit_stb   <= 1'b0;
      underrun  <= 1'b0;
      pulse_cnt <= '0;
    end else if (tick) begin
      bit_stb   <= 1'b1;
      underrun  <= ~in_valid;
      pad_hi    <= launch_pos;
      pad_lo    <= launch_neg;
      pulse_cnt <= (launch_pos || launch_neg) ? PW'(PULSE_W - 1) : '0;
    end else begin
      bit_stb  <= 1'b0;
      underrun <= 1'b0;
      if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - 1'b1;
      end else begin
        pad_hi <= 1'b0;
        pad_lo <= 1'b0;
      end
    end
  end

endmodule : e1_tx_line_driver
`default_nettype wire

// File: tb/tb_e1_tx_line_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_e1_tx_line_driver
// Purpose  : Self-checking bench for e1_tx_line_driver (DIV=15, PULSE_W=7).
//            Expected pad levels / underrun are queued when a symbol is
//            offered on a tick and popped when the bit strobe appears.
//            Trim scenarios are built when E1_TX_TRIM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e1_tx_line_driver;

  localparam int DIV     = 15;
  localparam int PULSE_W = 7;
  localparam int GAP     = DIV - 1;  // samples from bit_stb to next in_ready

  logic clk = 1'b0;
  logic rst;
  logic in_hi, in_lo, in_valid;
  logic in_ready, pad_hi, pad_lo, bit_stb, underrun;
  logic trim_slow, trim_fast;

  always #5 clk = ~clk;

  e1_tx_line_driver #(
    .DIV     (DIV),
    .PULSE_W (PULSE_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_hi     (in_hi),
    .in_lo     (in_lo),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pad_hi    (pad_hi),
    .pad_lo    (pad_lo),
    .bit_stb   (bit_stb),
    .underrun  (underrun)
`ifdef E1_TX_TRIM_EN
    ,
    .trim_slow (trim_slow),
    .trim_fast (trim_fast)
`endif
  );

  typedef struct {
    logic hi;
    logic lo;
    logic und;
    int   width;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   prev_w;      // expected pad-high cycles for the bit now on the line
  int   mark_cnt;    // observed pad-high cycles for that bit
  int   both_cnt;
  int   stray_cnt;   // bit_stb/underrun seen outside the strobe cycle

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_pads();
    if (pad_hi || pad_lo) mark_cnt++;
    if (pad_hi && pad_lo) both_cnt++;
  endtask

  // Offer one symbol, wait (bounded) for the slot, then check the bit that
  // just finished and the one that starts. ts/tf pulse trim mid-bit, and
  // tick_ts/tick_tf pulse trim on the accepting tick cycle itself.
  task automatic send(input string tag, input logic v, input logic hi,
                      input logic lo, input int gap,
                      input logic ts, input logic tf,
                      input logic tick_ts, input logic tick_tf);
    int   n;
    exp_t e;
    exp_t got;
    in_valid = v;
    in_hi    = hi;
    in_lo    = lo;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      trim_slow = 1'b0;
      trim_fast = 1'b0;
      n++;
      sample_pads();
      if (bit_stb || underrun) stray_cnt++;
    end
    check({tag, " slot gap"}, n, gap);
    check({tag, " prev pulse width"}, mark_cnt, prev_w);
    check({tag, " pads both high"}, both_cnt, 0);
    check({tag, " stray strobes"}, stray_cnt, 0);

    e.hi    = v & hi & ~lo;
    e.lo    = v & lo & ~hi;
    e.und   = ~v;
    e.width = (e.hi || e.lo) ? PULSE_W : 0;
    q.push_back(e);

    trim_slow = tick_ts;
    trim_fast = tick_tf;
    step();
    trim_slow = ts;
    trim_fast = tf;
    in_valid  = 1'b0;
    in_hi     = 1'b0;
    in_lo     = 1'b0;
    mark_cnt  = 0;
    both_cnt  = 0;
    stray_cnt = 0;
    sample_pads();

    got = q.pop_front();
    check({tag, " bit_stb"}, int'(bit_stb), 1);
    check({tag, " pad_hi"},  int'(pad_hi),  int'(got.hi));
    check({tag, " pad_lo"},  int'(pad_lo),  int'(got.lo));
    check({tag, " underrun"}, int'(underrun), int'(got.und));
    check({tag, " in_ready low"}, int'(in_ready), 0);
    prev_w = got.width;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    check("reset pad_hi",   int'(pad_hi),   0);
    check("reset pad_lo",   int'(pad_lo),   0);
    check("reset bit_stb",  int'(bit_stb),  0);
    check("reset underrun", int'(underrun), 0);
    rst       = 1'b0;
    prev_w    = 0;
    mark_cnt  = 0;
    both_cnt  = 0;
    stray_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; in_hi = 0; in_lo = 0; in_valid = 0;
    trim_slow = 0; trim_fast = 0;
    do_reset();

    // Idle for ~100 clks: every slot underruns, pads stay quiet.
    for (int i = 0; i < 7; i++) send("idle", 0, 0, 0, GAP, 0, 0, 0, 0);

    // Continuous positive marks.
    for (int i = 0; i < 4; i++) send("hi stream", 1, 1, 0, GAP, 0, 0, 0, 0);

    // Alternating +, -, space, +, -, underrun.
    send("alt +",     1, 1, 0, GAP, 0, 0, 0, 0);
    send("alt -",     1, 0, 1, GAP, 0, 0, 0, 0);
    send("alt space", 1, 0, 0, GAP, 0, 0, 0, 0);
    send("alt +2",    1, 1, 0, GAP, 0, 0, 0, 0);
    send("alt -2",    1, 0, 1, GAP, 0, 0, 0, 0);
    send("alt und",   0, 0, 0, GAP, 0, 0, 0, 0);
    send("alt -3",    1, 0, 1, GAP, 0, 0, 0, 0);

    // Illegal symbol goes out as a space, no underrun.
    send("illegal",   1, 1, 1, GAP, 0, 0, 0, 0);
    send("illegal2",  1, 1, 1, GAP, 0, 0, 0, 0);
    send("after ill", 1, 1, 0, GAP, 0, 0, 0, 0);

`ifdef E1_TX_TRIM_EN
    // Mid-bit slow trim lengthens the period after the next tick.
    send("slow req",  1, 1, 0, GAP,     1, 0, 0, 0);
    send("slow cur",  1, 0, 1, GAP,     0, 0, 0, 0);
    send("slow app",  1, 1, 0, GAP + 1, 0, 0, 0, 0);
    // Mid-bit fast trim shortens it; repeated pulses collapse into one.
    send("fast req",  1, 0, 1, GAP,     0, 1, 0, 0);
    send("fast cur",  1, 1, 0, GAP,     0, 0, 0, 0);
    send("fast app",  1, 0, 1, GAP - 1, 0, 0, 0, 0);
    // Both in one bit cancel.
    send("both req",  1, 1, 0, GAP,     1, 1, 0, 0);
    send("both cur",  0, 0, 0, GAP,     0, 0, 0, 0);
    send("both app",  1, 1, 0, GAP,     0, 0, 0, 0);
    // Trim on the tick cycle is deferred by one bit.
    send("tick req",  1, 0, 1, GAP,     0, 0, 1, 0);
    send("tick cur",  1, 1, 0, GAP,     0, 0, 0, 0);
    send("tick app",  1, 0, 1, GAP + 1, 0, 0, 0, 0);
    send("tick done", 1, 1, 0, GAP,     0, 0, 0, 0);
`endif

    // Reset in the middle of a positive pulse.
    send("pre rst", 1, 1, 0, GAP, 0, 0, 0, 0);
    step();
    step();
    check("mid pulse pad_hi", int'(pad_hi), 1);
    rst = 1'b1;
    step();
    check("rst kill pad_hi",  int'(pad_hi),  0);
    check("rst no bit_stb",   int'(bit_stb), 0);
    do_reset();
    send("post rst", 1, 0, 1, GAP, 0, 0, 0, 0);
    send("flush",    1, 0, 0, GAP, 0, 0, 0, 0);
    send("flush2",   0, 0, 0, GAP, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_e1_tx_line_driver
`default_nettype wire
